// File: rtl/alu_input_sequencer.sv
// Operand-entry sequencer: debounces enter/undo buttons and issues registered ALU load strobes.
// Optional undo handling is enabled by defining SEQ_UNDO_EN.
module alu_input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_enter,
    input  logic       btn_undo,
    output logic       load_A,
    output logic       load_B,
    output logic       load_Op,
    output logic       updateRes,
    output logic [3:0] state_leds
);

    localparam logic [1:0] S_WAIT_A   = 2'd0;
    localparam logic [1:0] S_WAIT_B   = 2'd1;
    localparam logic [1:0] S_WAIT_OP  = 2'd2;
    localparam logic [1:0] S_SHOW_RES = 2'd3;

`ifdef SEQ_UNDO_EN
    localparam int unsigned NBTN = 2;
`else
    localparam int unsigned NBTN = 1;
`endif
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync_q1;
    logic [NBTN-1:0] sync_q2;
    logic [NBTN-1:0] deb_level;
    logic [NBTN-1:0] deb_prev;
    logic [NBTN-1:0] press;
    logic [CW-1:0]   stab_cnt [NBTN];

    logic       enter_ev;
    logic       undo_ev;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       load_a_d;
    logic       load_b_d;
    logic       load_op_d;

`ifdef SEQ_UNDO_EN
    assign btn_raw = {btn_undo, btn_enter};
    assign undo_ev = press[1];
`else
    logic unused_undo;
    assign unused_undo = btn_undo;
    assign btn_raw     = btn_enter;
    assign undo_ev     = 1'b0;
`endif

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing synchronized samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            deb_level <= '0;
            deb_prev  <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            deb_prev <= deb_level;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (sync_q2[i] == deb_level[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == CNT_LAST) begin
                    deb_level[i] <= sync_q2[i];
                    stab_cnt[i]  <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press    = deb_level & ~deb_prev;
    assign enter_ev = press[0];

    always_comb begin
        state_d   = state_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_op_d = 1'b0;
        if (enter_ev) begin
            case (state_q)
                S_WAIT_A: begin
                    load_a_d = 1'b1;
                    state_d  = S_WAIT_B;
                end
                S_WAIT_B: begin
                    load_b_d = 1'b1;
                    state_d  = S_WAIT_OP;
                end
                S_WAIT_OP: begin
                    load_op_d = 1'b1;
                    state_d   = S_SHOW_RES;
                end
                default: state_d = S_WAIT_A;
            endcase
        end else if (undo_ev) begin
            case (state_q)
                S_SHOW_RES: state_d = S_WAIT_OP;
                S_WAIT_OP:  state_d = S_WAIT_B;
                default:    state_d = S_WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT_A;
            load_A    <= 1'b0;
            load_B    <= 1'b0;
            load_Op   <= 1'b0;
            updateRes <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_A    <= load_a_d;
            load_B    <= load_b_d;
            load_Op   <= load_op_d;
            updateRes <= load_Op;
        end
    end

    assign state_leds = 4'b0001 << state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed scenarios plus random button activity against a behavioural model.
module tb_alu_input_sequencer;

    localparam int DC = 4;
`ifdef SEQ_UNDO_EN
    localparam bit UNDO_EN = 1'b1;
`else
    localparam bit UNDO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       btn_enter;
    logic       btn_undo;
    logic       load_A;
    logic       load_B;
    logic       load_Op;
    logic       updateRes;
    logic [3:0] state_leds;

    int checks   = 0;
    int failures = 0;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_enter  (btn_enter),
        .btn_undo   (btn_undo),
        .load_A     (load_A),
        .load_B     (load_B),
        .load_Op    (load_Op),
        .updateRes  (updateRes),
        .state_leds (state_leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a level is accepted once the last DC synchronized samples all disagree with it.
    bit [15:0] he, hu;
    bit deb_e, deb_u, pend_e, pend_u;
    int m_st = 0;
    bit m_la, m_lb, m_lo, m_ur;

    function automatic bit settles(input bit [15:0] h, input bit lvl);
        for (int i = 1; i <= DC; i++)
            if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            he = '0; hu = '0;
            deb_e = 0; deb_u = 0; pend_e = 0; pend_u = 0;
            m_st = 0; m_la = 0; m_lb = 0; m_lo = 0; m_ur = 0;
        end else begin
            m_ur = m_lo;
            m_la = 0; m_lb = 0; m_lo = 0;
            if (pend_e) begin
                if (m_st == 0) m_la = 1;
                if (m_st == 1) m_lb = 1;
                if (m_st == 2) m_lo = 1;
                m_st = (m_st + 1) % 4;
            end else if (pend_u && UNDO_EN && m_st > 0) begin
                m_st = m_st - 1;
            end
            pend_e = 0;
            if (settles(he, deb_e)) begin
                deb_e  = ~deb_e;
                pend_e = deb_e;
            end
            pend_u = 0;
            if (settles(hu, deb_u)) begin
                deb_u  = ~deb_u;
                pend_u = deb_u;
            end
            he = {he[14:0], btn_enter};
            hu = {hu[14:0], btn_undo};
        end
    end

    always @(negedge clk) begin
        chk("load_A", load_A, m_la);
        chk("load_B", load_B, m_lb);
        chk("load_Op", load_Op, m_lo);
        chk("updateRes", updateRes, m_ur);
        chk("state_leds", state_leds, 1 << m_st);
    end

    // Holds the buttons for 10 cycles then releases for 10; reports first strobe offset from edge 0.
    task automatic press(input bit en, input bit un, output int k_ld, output int k_ur, output int which);
        @(negedge clk);
        btn_enter = en;
        btn_undo  = un;
        k_ld = -1; k_ur = -1; which = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k_ld < 0 && (load_A || load_B || load_Op)) begin
                k_ld  = k;
                which = {load_A, load_B, load_Op};
            end
            if (k_ur < 0 && updateRes) k_ur = k;
        end
        btn_enter = 0;
        btn_undo  = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async_rst_leds", state_leds, 4'b0001);
        chk("async_rst_strobes", {load_A, load_B, load_Op, updateRes}, 0);
        @(posedge clk);
        #2 reset_n = 1;
    endtask

    int k_ld, k_ur, which;

    initial begin
        btn_enter = 0;
        btn_undo  = 0;
        reset_n   = 1;
        #1 reset_n = 0;

        // Reset held with buttons toggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_enter = ~btn_enter;
            btn_undo  = (i % 3) == 0;
        end
        @(negedge clk);
        chk("rst_leds", state_leds, 4'b0001);
        chk("rst_strobes", {load_A, load_B, load_Op, updateRes}, 0);
        btn_enter = 0;
        btn_undo  = 0;
        #2 reset_n = 1;
        repeat (12) @(negedge clk);
        chk("post_rst_leds", state_leds, 4'b0001);

        // Full sequence
        press(1, 0, k_ld, k_ur, which);
        chk("A_lat", k_ld, 6);  chk("A_which", which, 3'b100); chk("A_leds", state_leds, 4'b0010);
        press(1, 0, k_ld, k_ur, which);
        chk("B_lat", k_ld, 6);  chk("B_which", which, 3'b010); chk("B_leds", state_leds, 4'b0100);
        press(1, 0, k_ld, k_ur, which);
        chk("Op_lat", k_ld, 6); chk("Op_which", which, 3'b001); chk("ur_lat", k_ur, 7);
        chk("Op_leds", state_leds, 4'b1000);

`ifdef SEQ_UNDO_EN
        press(0, 1, k_ld, k_ur, which);
        chk("undo1_nostrobe", k_ld, -1); chk("undo1_leds", state_leds, 4'b0100);
        press(0, 1, k_ld, k_ur, which);
        press(0, 1, k_ld, k_ur, which);
        chk("undo3_leds", state_leds, 4'b0001);
        press(0, 1, k_ld, k_ur, which);
        chk("undo_floor_leds", state_leds, 4'b0001); chk("undo_floor_nostrobe", k_ld, -1);
        press(1, 1, k_ld, k_ur, which);
        chk("both_lat", k_ld, 6); chk("both_which", which, 3'b100); chk("both_leds", state_leds, 4'b0010);
`else
        press(0, 1, k_ld, k_ur, which);
        chk("undo_ignored_nostrobe", k_ld, -1); chk("undo_ignored_leds", state_leds, 4'b1000);
        press(1, 0, k_ld, k_ur, which);
        chk("wrap_nostrobe", k_ld, -1); chk("wrap_leds", state_leds, 4'b0001);
        press(1, 1, k_ld, k_ur, which);
        chk("both_lat", k_ld, 6); chk("both_which", which, 3'b100); chk("both_leds", state_leds, 4'b0010);
`endif

        // Bounce rejection from WAIT_A
        pulse_reset();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~btn_enter;
            repeat (2) @(negedge clk);
        end
        btn_enter = 1;
        k_ld = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k_ld < 0 && (load_A || load_B || load_Op)) k_ld = k;
        end
        chk("bounce_lat", k_ld, 6);
        chk("bounce_leds", state_leds, 4'b0010);
        btn_enter = 0;
        repeat (10) @(negedge clk);

        // Reset mid-sequence in WAIT_OP
        press(1, 0, k_ld, k_ur, which);
        chk("mid_waitop_leds", state_leds, 4'b0100);
        pulse_reset();
        repeat (3) @(negedge clk);
        press(1, 0, k_ld, k_ur, which);
        chk("mid_after_lat", k_ld, 6); chk("mid_after_which", which, 3'b100);

        // Random activity including occasional asynchronous reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                @(negedge clk);
                btn_enter = $urandom_range(0, 1);
                btn_undo  = $urandom_range(0, 1);
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end
        btn_enter = 0;
        btn_undo  = 0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
